cnn_mac_engine: RTL

- Multi-channel, parametrised successor to the single-window convolution processing element in the mini-CNN datapath.
- Accepts one shared kernel and NUM_CH input windows over a valid/ready stream.
- Computes one saturating dot product per channel at one MAC per cycle, adds a per-job bias, and applies the selected post-op.
- Emits one result per channel on a valid/ready output stream, tagged with the channel index and a last flag.

---
 rtl/cnn_mac_engine.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_mac_engine.sv
// ============================================================================
// Module   : cnn_mac_engine
// Purpose  : Multi-channel conv MAC: shared kernel, NUM_CH windows, bias and post-op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cnn_mac_engine #(
    parameter int WIN_SIZE = 9,
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 32,
    parameter int SHIFT_W  = 5
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [1:0]                                   mode,
    input  logic signed [OUT_W-1:0]                      bias,
    input  logic [SHIFT_W-1:0]                           shift,
    input  logic signed [DATA_W-1:0]                     in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic signed [OUT_W-1:0]                      out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic                                         out_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAP_W = $clog2(WIN_SIZE);
    localparam int TOTAL = NUM_CH * WIN_SIZE;
    localparam int IDX_W = $clog2(TOTAL);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [OUT_W-1:0] c_acc_max = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_acc_min = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] c_q_max   = OUT_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [OUT_W-1:0] c_q_min   = ~c_q_max;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_K = 3'd1,
        S_LOAD_D = 3'd2,
        S_MAC    = 3'd3,
        S_POST   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_k [WIN_SIZE];
    logic signed [DATA_W-1:0]  r_d [TOTAL];
    logic [1:0]                r_mode;
    logic signed [OUT_W-1:0]   r_bias;
    logic [SHIFT_W-1:0]        r_shift;
    logic [TAP_W-1:0]          r_tap;
    logic [CH_W-1:0]           r_ch;
    logic [IDX_W-1:0]          r_cnt;
    logic signed [OUT_W-1:0]   r_acc;
    logic signed [OUT_W-1:0]   r_max;

    logic [IDX_W-1:0]          w_d_idx;
    logic signed [PROD_W-1:0]  w_a;
    logic signed [PROD_W-1:0]  w_b;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [OUT_W-1:0]   w_prod_ext;
    logic signed [OUT_W-1:0]   w_acc_base;
    logic signed [OUT_W-1:0]   w_max_base;
    logic signed [OUT_W-1:0]   w_acc_next;
    logic signed [OUT_W-1:0]   w_max_next;
    logic signed [OUT_W-1:0]   w_s;
    logic signed [OUT_W-1:0]   w_sh;
    logic signed [OUT_W-1:0]   w_q;
    logic signed [OUT_W-1:0]   w_post;
    logic                      w_beat;
    logic                      w_last_tap;
    logic                      w_last_ch;

    // Add in OUT_W+1 bits; disagreeing top bits mean overflow in that direction.
    function automatic logic signed [OUT_W-1:0] sat_add(
        input logic signed [OUT_W-1:0] a,
        input logic signed [OUT_W-1:0] b
    );
        logic signed [OUT_W:0] sum;
        sum = {a[OUT_W-1], a} + {b[OUT_W-1], b};
        if (sum[OUT_W] != sum[OUT_W-1]) begin
            return sum[OUT_W] ? c_acc_min : c_acc_max;
        end
        return sum[OUT_W-1:0];
    endfunction

    assign w_beat     = in_valid && in_ready;
    assign w_last_tap = (r_tap == TAP_W'(WIN_SIZE - 1));
    assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));

    assign w_d_idx    = IDX_W'(r_ch) * IDX_W'(WIN_SIZE) + IDX_W'(r_tap);
    assign w_a        = PROD_W'(r_d[w_d_idx]);
    assign w_b        = PROD_W'(r_k[r_tap]);
    assign w_prod     = w_a * w_b;
    assign w_prod_ext = OUT_W'(w_prod);

    assign w_acc_base = (r_tap == '0) ? '0 : r_acc;
    assign w_max_base = (r_tap == '0) ? c_acc_min : r_max;
    assign w_acc_next = sat_add(w_acc_base, w_prod_ext);
    assign w_max_next = (w_prod_ext > w_max_base) ? w_prod_ext : w_max_base;

    assign w_s  = sat_add(r_acc, r_bias);
    assign w_sh = w_s >>> r_shift;

    always_comb begin
        w_q = w_sh;
        if (w_sh > c_q_max) begin
            w_q = c_q_max;
        end else if (w_sh < c_q_min) begin
            w_q = c_q_min;
        end
    end

    always_comb begin
        w_post = w_s;
        case (r_mode)
            2'b00:   w_post = w_s[OUT_W-1] ? '0 : w_s;
            2'b01:   w_post = r_max;
            2'b10:   w_post = w_s;
            default: w_post = w_q;
        endcase
    end

    // Sample storage carries no reset: a job always rewrites it before use.
    always_ff @(posedge clk) begin
        if (w_beat && r_state == S_LOAD_K) begin
            r_k[r_tap] <= in_data;
        end
        if (w_beat && r_state == S_LOAD_D) begin
            r_d[r_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_bias    <= '0;
            r_shift   <= '0;
            r_tap     <= '0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_max     <= c_acc_min;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_bias   <= bias;
                        r_shift  <= shift;
                        r_tap    <= '0;
                        r_cnt    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_LOAD_K;
                    end
                end
                S_LOAD_K: begin
                    if (w_beat) begin
                        if (w_last_tap) begin
                            r_tap   <= '0;
                            r_state <= S_LOAD_D;
                        end else begin
                            r_tap <= r_tap + 1'b1;
                        end
                    end
                end
                S_LOAD_D: begin
                    if (w_beat) begin
                        if (r_cnt == IDX_W'(TOTAL - 1)) begin
                            in_ready <= 1'b0;
                            r_cnt    <= '0;
                            r_ch     <= '0;
                            r_tap    <= '0;
                            r_state  <= S_MAC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_max <= w_max_next;
                    if (w_last_tap) begin
                        r_tap   <= '0;
                        r_state <= S_POST;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_POST: begin
                    out_data  <= w_post;
                    out_ch    <= r_ch;
                    out_last  <= w_last_ch;
                    out_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            busy     <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= S_MAC;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
